float_multiplier_pipelined: RTL and testbench
=============================================

// Module: float_multiplier_pipelined
// PURPOSE
// Parametrised, pipelined minifloat multiplier; successor to the fixed e4m3 multiplier.
// - Operand format is selectable: sign | EXP_W exponent | MAN_W mantissa.
// - Three-stage pipeline with valid/ready handshake on both sides, so upstream can stream one product/cycle.
// - Round-to-nearest-even, subnormals, NaN propagation, overflow saturation; status flags per result.
// PARAMETERS
// EXP_W     4                   exponent field width (>=2)
// MAN_W     3                   mantissa field width (>=1)
// BIAS      2**(EXP_W-1)-1      exponent bias
// (W = 1+EXP_W+MAN_W, derived localparam; 8 at defaults)
// PORTS
// clock       in   1   rising-edge clock
// reset       in   1   asynchronous, active-low reset
// in_valid    in   1   operand pair a,b valid
// in_ready    out  1   block accepts a,b this cycle
// a           in   W   operand A
// b           in   W   operand B
// out_valid   out  1   y/flags valid
// out_ready   in   1   downstream accepts y this cycle
// y           out  W   product
// out_nan     out  1   y is NaN
// out_ovf     out  1   result saturated (overflow)
// out_inexact out  1   rounding discarded nonzero bits (incl. underflow to zero)
// BEHAVIOUR
// - Encoding: exp==0 -> subnormal (0.m * 2^(1-BIAS)); NaN = exp all-ones AND mant all-ones;
//   no infinity; max finite = exp all-ones, mant all-ones-1 (0x7E/0xFE at defaults).
// - reset low (async): all stage valid bits, out_valid, y, flags -> 0; in-flight data discarded.
//   Deassertion is sampled on the clock; first accept possible on the first edge after release.
// - advance = ~out_valid | out_ready; in_ready = advance (combinational). Handshake on valid&ready edge.
// - Pipeline moves only when advance=1; otherwise every stage holds. y/flags stable while out_valid&~out_ready.
// - Stage valid bits shift with advance; bubbles propagate as invalid. No reordering, no drops, no duplicates.
// - Latency: accepted at edge N -> out_valid high after edge N+3 when unstalled; throughput 1/cycle.
// - S1: unpack, hidden bit (1 for normal, 0 for subnormal), sign = sa^sb,
//   exp sum = ea'+eb'-BIAS (ea' = max(ea,1)), mantissa product (2*(MAN_W+1) bits), special-case detect.
// - S2: normalise (leading-one), shift right for exp<1 into subnormal range, collect guard/round/sticky.
// - S3: RNE (tie -> even LSB); mantissa carry-out increments exponent; pack; flags.
// - Specials, priority order:
//   1. NaN: either input NaN -> y = {sa^sb, all-ones}, out_nan=1.
//   2. Zero: either input zero (exp==0 & mant==0) -> y = {sa^sb, 0}, flags 0.
//   3. Overflow: rounded result > max finite -> y = {sign, max finite}, out_ovf=1, out_inexact=1.
//   4. Underflow: rounded magnitude 0 -> y = {sign, 0}, out_inexact=1.
// - Simultaneous accept and emit in one cycle is normal streaming; full pipe with out_ready=0 -> in_ready=0.
// TESTING (defaults EXP_W=4, MAN_W=3)
// 1 a=0x40 b=0x40 (2*2) -> y=0x48, flags 0, out_valid exactly 3 edges after accept.
// 2 a=0x39 b=0x39 (1.125^2=1.265625) -> y=0x3A, out_inexact=1; a=0x3C b=0x3C -> y=0x41 exact.
// 3 a=0x7E b=0x40 -> y=0x7E, out_ovf=1; a=0x7F b=0x38 -> y=0x7F, out_nan=1.
// 4 a=0x00 b=0xFE -> y=0x80; a=0x01 b=0x38 -> y=0x01; a=0x01 b=0x01 -> y=0x00, out_inexact=1.
// 5 stream 6 pairs back-to-back, out_ready=0 for 5 cycles mid-stream -> in_ready=0 while full,
//   y held stable, all 6 results in order, none lost/duplicated.
// 6 reset pulled low with 3 items in flight -> out_valid drops immediately (async);
//   no stale result emerges after release.

Source files
------------

// File: rtl/float_multiplier_pipelined.sv
// Pipelined minifloat multiplier (sign | EXP_W exponent | MAN_W mantissa) with RNE rounding,
// subnormals, NaN propagation and overflow saturation. Accept-to-output latency is three edges.
module float_multiplier_pipelined #(
  parameter int unsigned EXP_W = 4,
  parameter int unsigned MAN_W = 3,
  parameter int          BIAS  = 2 ** (EXP_W - 1) - 1,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         out_nan,
  output logic         out_ovf,
  output logic         out_inexact
);
  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + $clog2(PW) + 2;
  localparam int RW = EW + MAN_W;
  localparam logic [RW-1:0] MaxFin = RW'((64'd1 << (EXP_W + MAN_W)) - 64'd2);

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Operand register, then S1 (unpack/multiply), S2 (normalise), S3 (round/pack) into outputs.
  logic                 s0_valid_q;
  logic [W-1:0]         s0_a_q, s0_b_q;
  logic                 s1_valid_q, s1_sign_q, s1_nan_q, s1_zero_q;
  logic signed [EW-1:0] s1_exp_q;
  logic [PW-1:0]        s1_prod_q;
  logic                 s2_valid_q, s2_sign_q, s2_nan_q, s2_zero_q, s2_guard_q, s2_sticky_q;
  logic [EW-1:0]        s2_exp_q;
  logic [MAN_W-1:0]     s2_frac_q;

  logic [EXP_W-1:0]     ea, eb, ea_adj, eb_adj;
  logic [MAN_W-1:0]     ma, mb;
  logic                 s1_sign_d, s1_nan_d, s1_zero_d;
  logic signed [EW-1:0] s1_exp_d;
  logic [PW-1:0]        s1_prod_d;

  always_comb begin
    ea        = s0_a_q[W-2:MAN_W];
    eb        = s0_b_q[W-2:MAN_W];
    ma        = s0_a_q[MAN_W-1:0];
    mb        = s0_b_q[MAN_W-1:0];
    ea_adj    = (ea == '0) ? EXP_W'(1) : ea;
    eb_adj    = (eb == '0) ? EXP_W'(1) : eb;
    s1_sign_d = s0_a_q[W-1] ^ s0_b_q[W-1];
    s1_nan_d  = ((ea == '1) && (ma == '1)) || ((eb == '1) && (mb == '1));
    s1_zero_d = ((ea == '0) && (ma == '0)) || ((eb == '0) && (mb == '0));
    s1_exp_d  = EW'(ea_adj) + EW'(eb_adj) - EW'(BIAS);
    s1_prod_d = PW'({|ea, ma}) * PW'({|eb, mb});
  end

  int               lead, en, sh;
  logic [PW-1:0]    norm;
  logic [2*PW-1:0]  wide;
  logic [EW-1:0]    s2_exp_d;
  logic [MAN_W-1:0] s2_frac_d;
  logic             s2_guard_d, s2_sticky_d;

  always_comb begin
    lead = 0;
    for (int i = 0; i < PW; i++) begin
      if (s1_prod_q[i]) lead = i;
    end
    norm = s1_prod_q << (PW - 1 - lead);
    en   = int'(s1_exp_q) + lead - int'(2 * MAN_W);
    // Results below the normal range are denormalised; beyond PW the whole word is sticky.
    sh   = (en < 1) ? 1 - en : 0;
    if (sh > PW) sh = PW;
    wide        = {norm, {PW{1'b0}}} >> sh;
    s2_exp_d    = wide[2*PW-1] ? EW'(en) : '0;
    s2_frac_d   = wide[2*PW-2 -: MAN_W];
    s2_guard_d  = wide[2*PW-2-MAN_W];
    s2_sticky_d = |wide[2*PW-3-MAN_W:0];
  end

  logic          inc;
  logic [RW-1:0] res;
  logic [W-1:0]  y_d;
  logic          nan_d, ovf_d, inexact_d;

  always_comb begin
    inc = s2_guard_q & (s2_sticky_q | s2_frac_q[0]);
    // Mantissa carry ripples into the exponent field, including subnormal -> normal.
    res       = {s2_exp_q, s2_frac_q} + RW'(inc);
    y_d       = {s2_sign_q, res[W-2:0]};
    nan_d     = 1'b0;
    ovf_d     = 1'b0;
    inexact_d = s2_guard_q | s2_sticky_q;
    if (s2_nan_q) begin
      y_d       = {s2_sign_q, {(W-1){1'b1}}};
      nan_d     = 1'b1;
      inexact_d = 1'b0;
    end else if (s2_zero_q) begin
      y_d       = {s2_sign_q, {(W-1){1'b0}}};
      inexact_d = 1'b0;
    end else if (res > MaxFin) begin
      y_d       = {s2_sign_q, MaxFin[W-2:0]};
      ovf_d     = 1'b1;
      inexact_d = 1'b1;
    end else if (res == '0) begin
      y_d       = {s2_sign_q, {(W-1){1'b0}}};
      inexact_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s0_valid_q  <= 1'b0;
      s0_a_q      <= '0;
      s0_b_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_prod_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_nan_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_frac_q   <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      out_valid   <= 1'b0;
      y           <= '0;
      out_nan     <= 1'b0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (advance) begin
      s0_valid_q  <= in_valid;
      s0_a_q      <= a;
      s0_b_q      <= b;
      s1_valid_q  <= s0_valid_q;
      s1_sign_q   <= s1_sign_d;
      s1_nan_q    <= s1_nan_d;
      s1_zero_q   <= s1_zero_d;
      s1_exp_q    <= s1_exp_d;
      s1_prod_q   <= s1_prod_d;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_nan_q    <= s1_nan_q;
      s2_zero_q   <= s1_zero_q;
      s2_exp_q    <= s2_exp_d;
      s2_frac_q   <= s2_frac_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
      out_valid   <= s2_valid_q;
      y           <= y_d;
      out_nan     <= nan_d;
      out_ovf     <= ovf_d;
      out_inexact <= inexact_d;
    end
  end

endmodule

// File: tb/tb_float_multiplier_pipelined.sv
// Scoreboard bench for float_multiplier_pipelined at the default e4m3 format.
// Expected words are {nan, ovf, inexact, y}; a real-valued nearest-even model supplies random cases.
module tb_float_multiplier_pipelined;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] y;
  logic       out_nan, out_ovf, out_inexact;

  int total = 0;
  int bad = 0;
  logic [10:0] sbq[$];

  float_multiplier_pipelined dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .out_nan    (out_nan),
    .out_ovf    (out_ovf),
    .out_inexact(out_inexact)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog expired");
  end

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real mag(input logic [6:0] c);
    int e, m;
    e = int'(c[6:3]);
    m = int'(c[2:0]);
    if (e == 0) return real'(m) / 8.0 * pow2(-6);
    return (1.0 + real'(m) / 8.0) * pow2(e - 7);
  endfunction

  // Code 0x7F stands in as the next grid point above max finite; landing on it means overflow.
  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] z);
    logic s;
    real  p, lo, hi;
    int   c, r;
    logic inx;
    s = x[7] ^ z[7];
    if (x[6:0] == 7'h7F || z[6:0] == 7'h7F) return {3'b100, s, 7'h7F};
    if (x[6:0] == 7'h00 || z[6:0] == 7'h00) return {3'b000, s, 7'h00};
    p = mag(x[6:0]) * mag(z[6:0]);
    c = 0;
    for (int i = 1; i < 128; i++) if (mag(7'(i)) <= p) c = i;
    if (c == 127) return {3'b011, s, 7'h7E};
    lo = mag(7'(c));
    hi = mag(7'(c + 1));
    if (p == lo) begin
      r = c;
      inx = 1'b0;
    end else begin
      inx = 1'b1;
      if (p - lo < hi - p) r = c;
      else if (hi - p < p - lo) r = c + 1;
      else r = (c % 2 == 0) ? c : c + 1;
    end
    if (r == 127) return {3'b011, s, 7'h7E};
    return {2'b00, inx, s, 7'(r)};
  endfunction

  // Samples at the falling edge, logs accepted inputs, then advances past the next rising edge.
  task automatic tick(input logic [10:0] pv, output logic acc, output logic ov, output logic of,
                      output logic ir, output logic [10:0] obs);
    @(negedge clock);
    ov  = out_valid;
    ir  = in_ready;
    of  = out_valid & out_ready;
    acc = in_valid & in_ready;
    obs = {out_nan, out_ovf, out_inexact, y};
    if (acc) sbq.push_back(pv);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    total++;
    if (y !== 8'h00) begin
      bad++; $display("FAIL reset_y: got %h want 00", y);
    end
    total++;
    if ({out_nan, out_ovf, out_inexact} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {out_nan, out_ovf, out_inexact});
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL release_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_latency();
    logic acc, ov, of, ir;
    logic [10:0] obs, expv;
    int lat;
    out_ready = 1'b1;
    a = 8'h40;
    b = 8'h40;
    in_valid = 1'b1;
    tick(11'h048, acc, ov, of, ir, obs);
    in_valid = 1'b0;
    total++;
    if (acc !== 1'b1) begin
      bad++; $display("FAIL latency_accept: got %b want 1", acc);
    end
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      tick(11'h000, acc, ov, of, ir, obs);
      if (ov && lat < 0) lat = k;
      if (of) begin
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL latency_extra: got %h want none", obs);
        end else begin
          expv = sbq.pop_front();
          if (obs !== expv) begin
            bad++; $display("FAIL latency_value: got %h want %h", obs, expv);
          end
        end
      end
    end
    total++;
    if (lat != 3) begin
      bad++; $display("FAIL latency_edges: got %0d want 3", lat);
    end
  endtask

  task automatic test_directed();
    logic [7:0]  va[12], vb[12];
    logic [10:0] ve[12];
    logic acc, ov, of, ir;
    logic [10:0] obs, expv, pv;
    int sent = 0;
    va = '{8'h39, 8'h3C, 8'h7E, 8'h7F, 8'h00, 8'h01, 8'h01, 8'h39, 8'h39, 8'hC0, 8'h81, 8'h3F};
    vb = '{8'h39, 8'h3C, 8'h40, 8'h38, 8'hFE, 8'h38, 8'h01, 8'h44, 8'h42, 8'h40, 8'h7F, 8'h3F};
    ve = '{11'h13A, 11'h041, 11'h37E, 11'h47F, 11'h080, 11'h001,
           11'h100, 11'h146, 11'h143, 11'h0C8, 11'h4FF, 11'h146};
    out_ready = 1'b1;
    for (int t = 0; t < 60 && (sent < 12 || sbq.size() > 0); t++) begin
      if (sent < 12) begin
        in_valid = 1'b1; a = va[sent]; b = vb[sent]; pv = ve[sent];
      end else begin
        in_valid = 1'b0; pv = 11'h000;
      end
      tick(pv, acc, ov, of, ir, obs);
      if (acc) sent++;
      if (of) begin
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL directed_extra: got %h want none", obs);
        end else begin
          expv = sbq.pop_front();
          if (obs !== expv) begin
            bad++; $display("FAIL directed_value: got %h want %h", obs, expv);
          end
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (sent != 12 || sbq.size() != 0) begin
      bad++; $display("FAIL directed_done: got sent=%0d pending=%0d want 12/0", sent, sbq.size());
    end
  endtask

  task automatic test_random();
    logic acc, ov, of, ir;
    logic [10:0] obs, expv, pv;
    int sent = 0;
    for (int t = 0; t < 600 && (sent < 60 || sbq.size() > 0); t++) begin
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      if ($urandom_range(7) == 0) a = {a[7], 7'h7F};
      if ($urandom_range(7) == 0) b = {b[7], 4'h0, b[2:0]};
      in_valid  = (sent < 60) && ($urandom_range(3) != 0);
      out_ready = (sent >= 60) || ($urandom_range(3) != 0);
      pv = model(a, b);
      tick(pv, acc, ov, of, ir, obs);
      if (acc) sent++;
      if (of) begin
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL random_extra: got %h want none", obs);
        end else begin
          expv = sbq.pop_front();
          if (obs !== expv) begin
            bad++; $display("FAIL random_value: got %h want %h", obs, expv);
          end
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (sent != 60 || sbq.size() != 0) begin
      bad++; $display("FAIL random_done: got sent=%0d pending=%0d want 60/0", sent, sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic acc, ov, of, ir;
    logic [10:0] obs, expv, pv, held;
    int sent = 0;
    int got = 0;
    held = 11'h000;
    for (int t = 0; t < 60 && (sent < 6 || sbq.size() > 0); t++) begin
      in_valid = (sent < 6);
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      pv = model(a, b);
      out_ready = !(t >= 4 && t <= 8);
      tick(pv, acc, ov, of, ir, obs);
      if (acc) sent++;
      if (t >= 4 && t <= 8) begin
        total++;
        if (ov !== 1'b1 || ir !== 1'b0) begin
          bad++; $display("FAIL b2b_full: got valid=%b ready=%b want 1/0", ov, ir);
        end
        if (t == 4) held = obs;
        else begin
          total++;
          if (obs !== held) begin
            bad++; $display("FAIL b2b_hold: got %h want %h", obs, held);
          end
        end
      end
      if (of) begin
        got++;
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL b2b_extra: got %h want none", obs);
        end else begin
          expv = sbq.pop_front();
          if (obs !== expv) begin
            bad++; $display("FAIL b2b_value: got %h want %h", obs, expv);
          end
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 6 || sent != 6 || sbq.size() != 0) begin
      bad++; $display("FAIL b2b_count: got out=%0d in=%0d want 6/6", got, sent);
    end
  endtask

  task automatic test_async_reset();
    logic acc, ov, of, ir;
    logic [10:0] obs, expv, pv;
    int got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      pv = model(a, b);
      tick(pv, acc, ov, of, ir, obs);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick(11'h000, acc, ov, of, ir, obs);
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL rst_prefill: got %b want 1", out_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || y !== 8'h00 || {out_nan, out_ovf, out_inexact} !== 3'b000) begin
      bad++; $display("FAIL rst_async: got valid=%b y=%h want 0/00", out_valid, y);
    end
    sbq.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(11'h000, acc, ov, of, ir, obs);
      total++;
      if (ov !== 1'b0) begin
        bad++; $display("FAIL rst_stale: got valid=%b y=%h want 0", ov, obs[7:0]);
      end
    end
    a = 8'hC0;
    b = 8'hC0;
    in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick(11'h048, acc, ov, of, ir, obs);
      in_valid = 1'b0;
      if (of) begin
        got++;
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL rst_extra: got %h want none", obs);
        end else begin
          expv = sbq.pop_front();
          if (obs !== expv) begin
            bad++; $display("FAIL rst_value: got %h want %h", obs, expv);
          end
        end
      end
    end
    total++;
    if (got != 1) begin
      bad++; $display("FAIL rst_count: got %0d want 1", got);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
